associative_memory_argmin: RTL and testbench

//  Folded Hamming-distance associative memory with NUM_LABELS independent labels of NUM_CLASSES prototypes each.

---
 rtl/am_pkg.sv | 44 ++++
 rtl/am_fold_popcount.sv | 25 ++
 rtl/associative_memory_argmin.sv | 230 +++++++++++++++++++++++
 tb/tb_associative_memory_argmin.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : am_pkg                                                        |
// | Description: Shared types and helpers for the folded Hamming-distance      |
// |              associative memory (associative_memory_argmin).               |
// |              - am_state_t  : controller states IDLE / SCAN / DONE          |
// |              - NUM_FOLDS, DIST_W, CLS_W : derived sizes for the default    |
// |                configuration                                               |
// |              - idx_w()       : index width that never collapses to zero    |
// |              - proto_index() : flat prototype word address                 |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package am_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } am_state_t;

    localparam int HV_DIMENSION_DEFAULT = 2000;
    localparam int FOLD_WIDTH_DEFAULT   = 200;
    localparam int NUM_LABELS_DEFAULT   = 2;
    localparam int NUM_CLASSES_DEFAULT  = 2;

    localparam int NUM_FOLDS = HV_DIMENSION_DEFAULT / FOLD_WIDTH_DEFAULT;
    localparam int DIST_W    = $clog2(HV_DIMENSION_DEFAULT + 1);
    localparam int CLS_W     = $clog2(NUM_CLASSES_DEFAULT);

    // Width of an index into n items; a single item still gets one bit so
    // that ports and counters never become zero-width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Storage order: fold innermost, then class, then label. This matches the
    // scan order, so the read address simply walks upward during a scan.
    function automatic int proto_index(input int label, input int cls, input int fold,
                                       input int num_classes, input int num_folds);
        return (label * num_classes + cls) * num_folds + fold;
    endfunction

endpackage
`default_nettype wire

// File: rtl/am_fold_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : am_fold_popcount                                              |
// | Description: Combinational population count of one fold.                   |
// |   fold   in   FOLD_WIDTH   bits to count                                   |
// |   count  out  DIST_W       number of set bits                              |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module am_fold_popcount #(
    parameter int FOLD_WIDTH = 200,
    parameter int DIST_W     = 11
) (
    input  logic [FOLD_WIDTH-1:0] fold,
    output logic [DIST_W-1:0]     count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < FOLD_WIDTH; i++) begin
            count = count + DIST_W'(fold[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/associative_memory_argmin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : associative_memory_argmin                                     |
// | Description: Folded Hamming-distance associative memory. Captures one      |
// |              query hypervector, compares it fold-by-fold against every     |
// |              writable prototype and reports the nearest class per label.   |
// | Ports      :                                                               |
// |   clk, rst                  clock / asynchronous active-low reset          |
// |   proto_we/proto_ready      prototype fold write handshake                 |
// |   proto_label/class/fold    prototype fold address                         |
// |   proto_wdata               prototype fold contents                        |
// |   hvin_valid/hvin_ready     query handshake, hvin = query hypervector      |
// |   dout_valid/dout_ready     result handshake                               |
// |   class_out                 argmin class, label l at [l*CLS_W +: CLS_W]    |
// |   margin_out                second-best minus best distance per label      |
// |                             (only when AM_MARGIN_EN is defined)            |
// | Options    : `define AM_MARGIN_EN adds margin_out and second-best tracking |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module associative_memory_argmin
    import am_pkg::*;
#(
    parameter  int HV_DIMENSION = HV_DIMENSION_DEFAULT,
    parameter  int FOLD_WIDTH   = FOLD_WIDTH_DEFAULT,
    parameter  int NUM_LABELS   = NUM_LABELS_DEFAULT,
    parameter  int NUM_CLASSES  = NUM_CLASSES_DEFAULT,
    localparam int C_NUM_FOLDS  = HV_DIMENSION / FOLD_WIDTH,
    localparam int C_DIST_W     = $clog2(HV_DIMENSION + 1),
    localparam int C_CLS_W      = idx_w(NUM_CLASSES),
    localparam int C_LBL_W      = idx_w(NUM_LABELS),
    localparam int C_FOLD_IW    = idx_w(C_NUM_FOLDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            proto_we,
    output logic                            proto_ready,
    input  logic [C_LBL_W-1:0]              proto_label,
    input  logic [C_CLS_W-1:0]              proto_class,
    input  logic [C_FOLD_IW-1:0]            proto_fold,
    input  logic [FOLD_WIDTH-1:0]           proto_wdata,
    input  logic                            hvin_valid,
    output logic                            hvin_ready,
    input  logic [HV_DIMENSION-1:0]         hvin,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [NUM_LABELS*C_CLS_W-1:0]   class_out
`ifdef AM_MARGIN_EN
    ,
    output logic [NUM_LABELS*C_DIST_W-1:0]  margin_out
`endif
);

    localparam int C_NUM_WORDS = NUM_LABELS * NUM_CLASSES * C_NUM_FOLDS;
    localparam int C_ADDR_W    = idx_w(C_NUM_WORDS);

    am_state_t                       r_state, w_state_next;
    logic [HV_DIMENSION-1:0]         r_query;
    logic [FOLD_WIDTH-1:0]           r_mem [C_NUM_WORDS];
    logic [C_FOLD_IW-1:0]            r_fold;
    logic [C_CLS_W-1:0]              r_cls;
    logic [C_LBL_W-1:0]              r_lbl;
    logic [C_DIST_W-1:0]             r_dist_acc, r_best_dist;
    logic [C_CLS_W-1:0]              r_best_cls;
    logic [NUM_LABELS*C_CLS_W-1:0]   r_class_acc, r_class_out, w_class_final;

    logic [C_ADDR_W-1:0]             w_wr_addr, w_rd_addr;
    logic [FOLD_WIDTH-1:0]           w_qfold, w_pfold;
    logic [C_DIST_W-1:0]             w_pop, w_total, w_best_dist_n;
    logic [C_CLS_W-1:0]              w_best_cls_n;
    logic                            w_hvin_fire, w_wr_en, w_take_best;
    logic                            w_last_fold, w_last_cls, w_last_lbl, w_scan_end;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        hvin_ready   = 1'b0;
        proto_ready  = 1'b0;
        dout_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                hvin_ready  = 1'b1;
                proto_ready = 1'b1;
                if (hvin_valid) w_state_next = SCAN;
            end
            SCAN: begin
                if (w_scan_end) w_state_next = DONE;
            end
            DONE: begin
                dout_valid = 1'b1;
                if (dout_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_hvin_fire = hvin_valid && hvin_ready;
    assign w_last_fold = (r_fold == C_FOLD_IW'(C_NUM_FOLDS - 1));
    assign w_last_cls  = (r_cls == C_CLS_W'(NUM_CLASSES - 1));
    assign w_last_lbl  = (r_lbl == C_LBL_W'(NUM_LABELS - 1));
    assign w_scan_end  = (r_state == SCAN) && w_last_fold && w_last_cls && w_last_lbl;

    // ---------------- storage (no reset) ----------------
    // Out-of-range fold numbers would alias into the next class, so they are dropped.
    assign w_wr_en   = proto_we && proto_ready && (int'(proto_fold) < C_NUM_FOLDS);
    assign w_wr_addr = C_ADDR_W'(proto_index(int'(proto_label), int'(proto_class),
                                             int'(proto_fold), NUM_CLASSES, C_NUM_FOLDS));
    assign w_rd_addr = C_ADDR_W'(proto_index(int'(r_lbl), int'(r_cls),
                                             int'(r_fold), NUM_CLASSES, C_NUM_FOLDS));

    always_ff @(posedge clk) begin
        if (w_wr_en)     r_mem[w_wr_addr] <= proto_wdata;
        if (w_hvin_fire) r_query          <= hvin;
    end

    assign w_pfold = r_mem[w_rd_addr];

    always_comb begin
        w_qfold = '0;
        for (int f = 0; f < C_NUM_FOLDS; f++) begin
            if (r_fold == C_FOLD_IW'(f)) w_qfold = r_query[f*FOLD_WIDTH +: FOLD_WIDTH];
        end
    end

    am_fold_popcount #(
        .FOLD_WIDTH (FOLD_WIDTH),
        .DIST_W     (C_DIST_W)
    ) u_popcount (
        .fold  (w_qfold ^ w_pfold),
        .count (w_pop)
    );

    // ---------------- distance / argmin ----------------
    assign w_total       = r_dist_acc + w_pop;
    // Strict less-than keeps the lower class index on ties.
    assign w_take_best   = (r_cls == '0) || (w_total < r_best_dist);
    assign w_best_dist_n = w_take_best ? w_total : r_best_dist;
    assign w_best_cls_n  = w_take_best ? r_cls   : r_best_cls;

    // Per-label results collect in r_class_acc and only move to class_out when
    // the whole scan completes, so class_out never shows a half-finished query.
    always_comb begin
        w_class_final = r_class_acc;
        for (int l = 0; l < NUM_LABELS; l++) begin
            if (r_lbl == C_LBL_W'(l)) w_class_final[l*C_CLS_W +: C_CLS_W] = w_best_cls_n;
        end
    end

`ifdef AM_MARGIN_EN
    logic [C_DIST_W-1:0]             r_second, w_second_n;
    logic [NUM_LABELS*C_DIST_W-1:0]  r_margin_acc, r_margin_out, w_margin_final;

    always_comb begin
        w_second_n = r_second;
        if (r_cls == '0)                w_second_n = '1;
        else if (w_total < r_best_dist) w_second_n = r_best_dist;
        else if (w_total < r_second)    w_second_n = w_total;
        w_margin_final = r_margin_acc;
        for (int l = 0; l < NUM_LABELS; l++) begin
            if (r_lbl == C_LBL_W'(l))
                w_margin_final[l*C_DIST_W +: C_DIST_W] = w_second_n - w_best_dist_n;
        end
    end

    assign margin_out = r_margin_out;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fold      <= '0;
            r_cls       <= '0;
            r_lbl       <= '0;
            r_dist_acc  <= '0;
            r_best_dist <= '0;
            r_best_cls  <= '0;
            r_class_acc <= '0;
            r_class_out <= '0;
`ifdef AM_MARGIN_EN
            r_second     <= '0;
            r_margin_acc <= '0;
            r_margin_out <= '0;
`endif
        end else begin
            if (w_hvin_fire) begin
                r_fold     <= '0;
                r_cls      <= '0;
                r_lbl      <= '0;
                r_dist_acc <= '0;
            end
            if (r_state == SCAN) begin
                if (!w_last_fold) begin
                    r_fold     <= r_fold + C_FOLD_IW'(1);
                    r_dist_acc <= w_total;
                end else begin
                    r_fold      <= '0;
                    r_dist_acc  <= '0;
                    r_best_dist <= w_best_dist_n;
                    r_best_cls  <= w_best_cls_n;
`ifdef AM_MARGIN_EN
                    r_second    <= w_second_n;
`endif
                    if (w_last_cls) begin
                        r_cls       <= '0;
                        r_lbl       <= w_last_lbl ? '0 : r_lbl + C_LBL_W'(1);
                        r_class_acc <= w_class_final;
`ifdef AM_MARGIN_EN
                        r_margin_acc <= w_margin_final;
`endif
                    end else begin
                        r_cls <= r_cls + C_CLS_W'(1);
                    end
                end
            end
            if (w_scan_end) begin
                r_class_out <= w_class_final;
`ifdef AM_MARGIN_EN
                r_margin_out <= w_margin_final;
`endif
            end
        end
    end

    assign class_out = r_class_out;

endmodule
`default_nettype wire

// File: tb/tb_associative_memory_argmin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_associative_memory_argmin                                  |
// | Description: Directed self-checking bench for associative_memory_argmin,   |
// |              configured with 2 labels x 4 classes x 5 folds of 400 bits.   |
// |              class_out layout: [1:0] label 0, [3:2] label 1.               |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_associative_memory_argmin;

    localparam int HV = 2000;
    localparam int FW = 400;
    localparam int NL = 2;
    localparam int NC = 4;
    localparam int NF = 5;
    localparam int DW = 11;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           proto_we;
    logic           proto_ready;
    logic [0:0]     proto_label;
    logic [1:0]     proto_class;
    logic [2:0]     proto_fold;
    logic [FW-1:0]  proto_wdata;
    logic           hvin_valid;
    logic           hvin_ready;
    logic [HV-1:0]  hvin;
    logic           dout_valid;
    logic           dout_ready;
    logic [NL*CW-1:0] class_out;
`ifdef AM_MARGIN_EN
    logic [NL*DW-1:0] margin_out;
`endif

    int total = 0;
    int bad   = 0;
    logic [HV-1:0] qb;

    associative_memory_argmin #(
        .HV_DIMENSION (HV),
        .FOLD_WIDTH   (FW),
        .NUM_LABELS   (NL),
        .NUM_CLASSES  (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .proto_we    (proto_we),
        .proto_ready (proto_ready),
        .proto_label (proto_label),
        .proto_class (proto_class),
        .proto_fold  (proto_fold),
        .proto_wdata (proto_wdata),
        .hvin_valid  (hvin_valid),
        .hvin_ready  (hvin_ready),
        .hvin        (hvin),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .class_out   (class_out)
`ifdef AM_MARGIN_EN
        ,
        .margin_out  (margin_out)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // n set bits starting at bit lo
    function automatic logic [HV-1:0] span(input int lo, input int n);
        logic [HV-1:0] m;
        m = '0;
        for (int i = lo; i < lo + n; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic write_fold(input int l, input int c, input int f, input logic [FW-1:0] d);
        int n;
        n = 0;
        proto_we    = 1'b1;
        proto_label = l[0:0];
        proto_class = c[1:0];
        proto_fold  = f[2:0];
        proto_wdata = d;
        while (proto_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (proto_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_accept proto_ready=%b want=1", proto_ready);
        end
        @(posedge clk); #1;
        proto_we = 1'b0;
    endtask

    task automatic write_proto(input int l, input int c, input logic [HV-1:0] hv);
        for (int f = 0; f < NF; f++) write_fold(l, c, f, hv[f*FW +: FW]);
    endtask

    // Fires one query and waits for dout_valid; lat counts cycles from the
    // hvin_fire cycle to the first cycle with dout_valid high.
    task automatic run_query(input logic [HV-1:0] q, output int lat);
        int n;
        n = 0;
        hvin       = q;
        hvin_valid = 1'b1;
        while (hvin_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        hvin_valid = 1'b0;
        proto_we   = 1'b0;
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (dout_valid !== 1'b1) begin
            bad++;
            $display("FAIL query_timeout dout_valid=%b want=1", dout_valid);
        end
    endtask

    task automatic ack();
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b want=0", dout_valid); end
        total++;
        if (class_out !== 4'h0) begin bad++; $display("FAIL reset_class_out got=%h want=0", class_out); end
        total++;
        if (hvin_ready !== 1'b1) begin bad++; $display("FAIL reset_hvin_ready got=%b want=1", hvin_ready); end
        total++;
        if (proto_ready !== 1'b1) begin bad++; $display("FAIL reset_proto_ready got=%b want=1", proto_ready); end
`ifdef AM_MARGIN_EN
        total++;
        if (margin_out !== '0) begin bad++; $display("FAIL reset_margin got=%h want=0", margin_out); end
`endif
    endtask

    task automatic test_basic();
        int lat;
        write_proto(0, 0, qb ^ span(0, 100));
        write_proto(0, 1, qb);
        write_proto(0, 2, qb ^ span(0, 50));
        write_proto(0, 3, qb ^ span(100, 7));
        write_proto(1, 0, qb);
        write_proto(1, 1, qb ^ span(0, 3));
        write_proto(1, 2, qb ^ span(5, 1));
        write_proto(1, 3, ~qb);
        run_query(qb, lat);
        total++;
        if (lat !== 41) begin bad++; $display("FAIL basic_latency got=%0d want=41", lat); end
        total++;
        if (class_out !== 4'h1) begin bad++; $display("FAIL basic_class got=%h want=1", class_out); end
        total++;
        if (hvin_ready !== 1'b0) begin bad++; $display("FAIL basic_done_hvin_ready got=%b want=0", hvin_ready); end
`ifdef AM_MARGIN_EN
        total++;
        if (margin_out !== {11'd1, 11'd7}) begin
            bad++; $display("FAIL basic_margin got=%h want=%h", margin_out, {11'd1, 11'd7});
        end
`endif
        ack();
        total++;
        if (hvin_ready !== 1'b1 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL basic_ack hvin_ready=%b dout_valid=%b want=1,0", hvin_ready, dout_valid);
        end
    endtask

    task automatic test_tie();
        int lat;
        write_proto(0, 0, qb ^ span(0, 37));
        write_proto(0, 1, qb ^ span(1963, 37));
        write_proto(0, 2, qb ^ span(0, 100));
        write_proto(0, 3, qb ^ span(500, 200));
        write_proto(1, 0, qb ^ span(0, 50));
        write_proto(1, 1, qb ^ span(0, 40));
        write_proto(1, 2, qb ^ span(1000, 40));
        write_proto(1, 3, qb ^ span(1500, 41));
        run_query(qb, lat);
        total++;
        if (class_out !== 4'h4) begin bad++; $display("FAIL tie_class got=%h want=4", class_out); end
`ifdef AM_MARGIN_EN
        total++;
        if (margin_out !== '0) begin bad++; $display("FAIL tie_margin got=%h want=0", margin_out); end
`endif
        ack();
    endtask

    task automatic test_max_distance();
        int lat;
        write_proto(0, 0, '1);
        write_proto(0, 1, '0);
        write_proto(0, 2, '0);
        write_proto(0, 3, '0);
        write_proto(1, 0, '1);
        write_proto(1, 1, span(0, 1000));
        write_proto(1, 2, '1);
        write_proto(1, 3, '1);
        run_query('0, lat);
        total++;
        if (class_out !== 4'h5) begin bad++; $display("FAIL maxdist_class got=%h want=5", class_out); end
`ifdef AM_MARGIN_EN
        total++;
        if (margin_out !== {11'd1000, 11'd0}) begin
            bad++; $display("FAIL maxdist_margin got=%h want=%h", margin_out, {11'd1000, 11'd0});
        end
`endif
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        run_query('0, lat);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dout_valid !== 1'b1) begin bad++; $display("FAIL hold_dout_valid cyc=%0d got=%b want=1", i, dout_valid); end
            total++;
            if (class_out !== 4'h5) begin bad++; $display("FAIL hold_class cyc=%0d got=%h want=5", i, class_out); end
            total++;
            if (hvin_ready !== 1'b0 || proto_ready !== 1'b0) begin
                bad++; $display("FAIL hold_ready cyc=%0d hvin_ready=%b proto_ready=%b want=0,0", i, hvin_ready, proto_ready);
            end
            @(posedge clk); #1;
        end
        ack();
        total++;
        if (hvin_ready !== 1'b1 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL hold_release hvin_ready=%b dout_valid=%b want=1,0", hvin_ready, dout_valid);
        end
        total++;
        if (class_out !== 4'h5) begin bad++; $display("FAIL hold_class_kept got=%h want=5", class_out); end
    endtask

    task automatic test_reset_midscan();
        int lat;
        int seen;
        hvin       = '0;
        hvin_valid = 1'b1;
        @(posedge clk); #1;
        hvin_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        // now in the SCAN cycle that processes fold 3
        #2 rst = 1'b0;
        #1;
        total++;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL rstscan_dout_valid got=%b want=0", dout_valid); end
        total++;
        if (class_out !== 4'h0) begin bad++; $display("FAIL rstscan_class got=%h want=0", class_out); end
        total++;
        if (hvin_ready !== 1'b1) begin bad++; $display("FAIL rstscan_hvin_ready got=%b want=1", hvin_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            if (dout_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rstscan_no_result valid_cycles=%0d want=0", seen); end
        total++;
        if (hvin_ready !== 1'b1) begin bad++; $display("FAIL rstscan_idle got=%b want=1", hvin_ready); end
        run_query('0, lat);
        total++;
        if (lat !== 41) begin bad++; $display("FAIL rstscan_latency got=%0d want=41", lat); end
        total++;
        if (class_out !== 4'h5) begin bad++; $display("FAIL rstscan_fresh_class got=%h want=5", class_out); end
        ack();
    endtask

    task automatic test_write_during_scan();
        int lat;
        total++;
        if (hvin_ready !== 1'b1) begin bad++; $display("FAIL wscan_start_idle got=%b want=1", hvin_ready); end
        hvin       = '0;
        hvin_valid = 1'b1;
        @(posedge clk); #1;
        hvin_valid  = 1'b0;
        proto_we    = 1'b1;
        proto_label = 1'b0;
        proto_class = 2'd1;
        proto_fold  = 3'd0;
        proto_wdata = '1;
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 200) begin
            total++;
            if (proto_ready !== 1'b0) begin bad++; $display("FAIL wscan_proto_ready cyc=%0d got=%b want=0", lat, proto_ready); end
            @(posedge clk); #1; lat++;
        end
        total++;
        if (proto_ready !== 1'b0) begin bad++; $display("FAIL wscan_done_proto_ready got=%b want=0", proto_ready); end
        proto_we = 1'b0;
        total++;
        if (lat !== 41) begin bad++; $display("FAIL wscan_latency got=%0d want=41", lat); end
        total++;
        if (class_out !== 4'h5) begin bad++; $display("FAIL wscan_ignored got=%h want=5", class_out); end
        ack();
        write_proto(0, 1, '1);
        run_query('0, lat);
        total++;
        if (class_out !== 4'h6) begin bad++; $display("FAIL wscan_reissued got=%h want=6", class_out); end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        write_proto(1, 3, span(0, 1200));
        run_query('0, lat);
        total++;
        if (class_out !== 4'h6) begin bad++; $display("FAIL b2b_first got=%h want=6", class_out); end
        ack();
        total++;
        if (hvin_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", hvin_ready); end
        // write in the same cycle as the next hvin_fire
        proto_we    = 1'b1;
        proto_label = 1'b1;
        proto_class = 2'd3;
        proto_fold  = 3'd0;
        proto_wdata = '0;
        run_query('0, lat);
        total++;
        if (lat !== 41) begin bad++; $display("FAIL b2b_latency got=%0d want=41", lat); end
        total++;
        if (class_out !== 4'hE) begin bad++; $display("FAIL b2b_second got=%h want=e", class_out); end
        ack();
    endtask

    initial begin
        rst         = 1'b0;
        proto_we    = 1'b0;
        proto_label = '0;
        proto_class = '0;
        proto_fold  = '0;
        proto_wdata = '0;
        hvin_valid  = 1'b0;
        hvin        = '0;
        dout_ready  = 1'b0;
        for (int i = 0; i < HV; i++) qb[i] = (i % 3 == 0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_tie();
        test_max_distance();
        test_backpressure();
        test_reset_midscan();
        test_write_during_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
